rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Parametrised reset sequencer for N reset domains. Clocked from the always-running src_clk. It waits for PLL lock, holds all domains in reset for a programmable window, then releases them one at a time in index order. Each domain's reset is re-synchronised to its own clock. The block also supports a software-requested re-reset and re-sequences after PLL lock loss. It sits at the top level beside the clocking wizard and drives the per-domain reset nets of the MAC, PHY and switch cores.

## Interface
- N_DOM, 3: number of reset domains, ≥1.
- WAIT_CYC, 128: src_clk cycles spent in WAIT after lock is seen, ≥1.
- RST_CYC, 128: src_clk cycles all domains are held in reset in RSET, ≥1.
- STAGGER, 16: src_clk cycles between consecutive domain releases, ≥1.
- SYNC_STG, 2: synchroniser depth per output domain, ≥2.
- INIT_MASK, 3'b011: per-domain source value held from arstn until RSET (1 = deasserted, 0 = asserted).
- src_clk  in  1  sequencer clock, free-running.
- arstn  in  1  reset, asynchronous, active-low; clock src_clk.
- dom_clk  in  N_DOM  per-domain output clocks.
- pll_locked  in  1  PLL lock, asynchronous to src_clk.
- sw_rst_req  in  1  level, src_clk domain; requests a full re-sequence.
- rstn_out  out  N_DOM  per-domain active-low resets, synchronous to dom_clk[i].
- rst_busy  out  1  high whenever the state is not IDLE.
- rst_done  out  1  one-cycle pulse in the first cycle of IDLE.

## Operation
- pll_locked passes through a 2-flop synchroniser in src_clk, giving lock_s.
- One-hot states: INIT, WAIT, RSET, RELS, IDLE.
  - INIT → WAIT when lock_s = 1.
  - WAIT → RSET after WAIT_CYC cycles in WAIT.
  - RSET → RELS after RST_CYC cycles in RSET. If N_DOM = 1, RSET goes directly to IDLE.
  - RELS → IDLE on the edge that releases domain N_DOM-1.
  - IDLE → RSET when sw_rst_req = 1. sw_rst_req is ignored in every other state.
- Single shared counter, width clog2(max(WAIT_CYC, RST_CYC, STAGGER)+1). Cleared on every state change; increments otherwise; held at 0 in INIT and IDLE.
- src_rstn[N_DOM-1:0] is registered and updated on the same edge as the state transition, decoded from the next state.
  - arstn value: INIT_MASK.
  - Entry to RSET: all 0.
  - RELS entered at edge E: bit k set to 1 at edge E + k·STAGGER.
  - IDLE: all 1.
- Domain sync: rstn_out[i] comes from a SYNC_STG-deep chain clocked by dom_clk[i], with data input src_rstn[i]. The chain is asynchronously cleared by arstn. Assertion and release therefore both lag by SYNC_STG dom_clk edges, except arstn, which asserts immediately.
- rst_busy and rst_done are registered. Both are 0 during arstn. rst_busy = 1 from the first edge after arstn release.
- arstn mid-sequence: everything returns to reset values immediately, and the sequence restarts at INIT.

## Timing
- Edges counted from the first src_clk edge after arstn release, with pll_locked stable high:
  - lock_s = 1 after edge 2; WAIT entered at edge 3.
  - RSET entered at edge 3 + WAIT_CYC.
  - RELS entered at edge 3 + WAIT_CYC + RST_CYC; domain 0 released on that same edge.
  - IDLE entered at RELS entry + (N_DOM-1)·STAGGER.
- sw_rst_req high in IDLE at edge T: RSET and src_rstn = 0 at edge T+1. The release timing then matches the cold sequence.
- Simultaneous lock loss and sw_rst_req: lock loss wins.

## Configuration
- RST_SEQ_LOCK_MON_EN defined: lock_s = 0 in WAIT, RSET, RELS or IDLE sends the state to INIT on the next edge.
  - The counter clears and src_rstn is forced to all 0, overriding INIT_MASK.
  - src_rstn stays 0 until RELS of the new sequence.
- Undefined: lock_s is examined only in INIT. Later lock loss is ignored.

## Structure
- Package rst_pkg: one-hot state localparams (ST_INIT=1, ST_WAIT=2, ST_RSET=4, ST_RELS=8, ST_IDLE=16) and a clog2 helper function.
- Sub-module rst_sync (parameter SYNC_STG; ports clk, arstn, d, q), instanced N_DOM times in a generate loop. A second instance with SYNC_STG=2 synchronises pll_locked.

## Test plan
All scenarios use N_DOM=3, WAIT_CYC=8, RST_CYC=4, STAGGER=2, INIT_MASK=3'b011, SYNC_STG=2.
- Cold start, lock high: src_rstn = 011 until edge 11; 000 from edge 11 to 14; 001 at edge 15, 011 at 17, 111 at 19. rst_done pulses after edge 19; rst_busy falls at edge 19.
- Lock delayed: pll_locked rises 20 cycles after arstn release → WAIT is entered 3 edges later, and the whole sequence shifts by 20.
- sw_rst_req pulsed in IDLE at edge T → src_rstn = 000 at T+1, 001 at T+5, 111 at T+9, rst_done at T+9. The same request during WAIT has no effect.
- With RST_SEQ_LOCK_MON_EN, drop pll_locked in RELS after domain 0 is released → INIT and src_rstn = 000 within 3 edges. On re-lock, the full sequence repeats. Without the macro, the sequence completes unchanged.
- arstn pulsed low mid-RSET → rstn_out = 000 immediately and the state returns to INIT. On release, the cold-start timing recurs.
- dom_clk[2] at 1/3 the src_clk frequency → rstn_out[2] rises exactly 2 dom_clk[2] edges after src_rstn[2], with no glitch.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared constants for the reset sequencer: one-hot state codes and a ceil-log2 helper.
package rst_pkg;

  localparam logic [4:0] ST_INIT = 5'b00001;
  localparam logic [4:0] ST_WAIT = 5'b00010;
  localparam logic [4:0] ST_RSET = 5'b00100;
  localparam logic [4:0] ST_RELS = 5'b01000;
  localparam logic [4:0] ST_IDLE = 5'b10000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = unsigned'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset/level synchroniser: SYNC_STG-deep flop chain, asynchronously cleared by arstn.
module rst_sync #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STG-1:0] sync_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STG-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for PLL lock, holds all domains in reset, then releases them in order.
// Define RST_SEQ_LOCK_MON_EN to re-sequence from INIT whenever lock is lost after INIT.
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned     N_DOM     = 3,
  parameter int unsigned     WAIT_CYC  = 128,
  parameter int unsigned     RST_CYC   = 128,
  parameter int unsigned     STAGGER   = 16,
  parameter int unsigned     SYNC_STG  = 2,
  parameter logic [N_DOM-1:0] INIT_MASK = N_DOM'(3'b011)
) (
  input  logic             src_clk,
  input  logic             arstn,
  input  logic [N_DOM-1:0] dom_clk,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  output logic [N_DOM-1:0] rstn_out,
  output logic             rst_busy,
  output logic             rst_done
);

  localparam int unsigned MAX_CYC = (WAIT_CYC > RST_CYC) ?
                                    ((WAIT_CYC > STAGGER) ? WAIT_CYC : STAGGER) :
                                    ((RST_CYC > STAGGER) ? RST_CYC : STAGGER);
  localparam int unsigned CNT_W   = clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER - 1);

  logic             lock_s;
  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_DOM-1:0] src_rstn_q, src_rstn_d;
  logic [N_DOM-1:0] rel_next;
  logic             rst_busy_q, rst_done_q;

  rst_sync #(
    .SYNC_STG (2)
  ) u_lock_sync (
    .clk   (src_clk),
    .arstn (arstn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    src_rstn_d = src_rstn_q;
    // Releasing one more domain shifts a 1 in from bit 0.
    rel_next   = (src_rstn_q << 1) | N_DOM'(1);

    unique case (state_q)
      ST_INIT: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_RSET;
      end
      ST_RSET: begin
        if (cnt_q == RST_LAST) state_d = (N_DOM == 1) ? ST_IDLE : ST_RELS;
      end
      ST_RELS: begin
        // Counter measures one stagger slot at a time.
        if (cnt_q == STG_LAST) begin
          cnt_d      = '0;
          src_rstn_d = rel_next;
          if (rel_next[N_DOM-1]) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (sw_rst_req) state_d = ST_RSET;
      end
      default: state_d = ST_INIT;
    endcase

`ifdef RST_SEQ_LOCK_MON_EN
    if ((state_q != ST_INIT) && !lock_s) state_d = ST_INIT;
`endif

    if (state_d != state_q) begin
      cnt_d = '0;
      unique case (state_d)
        ST_INIT: src_rstn_d = '0;
        ST_WAIT: src_rstn_d = src_rstn_q;
        ST_RSET: src_rstn_d = '0;
        ST_RELS: src_rstn_d = N_DOM'(1);
        ST_IDLE: src_rstn_d = '1;
        default: src_rstn_d = '0;
      endcase
    end
  end

  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      src_rstn_q <= INIT_MASK;
      rst_busy_q <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_rstn_q <= src_rstn_d;
      rst_busy_q <= (state_d != ST_IDLE);
      rst_done_q <= (state_d == ST_IDLE) && (state_q != ST_IDLE);
    end
  end

  assign rst_busy = rst_busy_q;
  assign rst_done = rst_done_q;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    rst_sync #(
      .SYNC_STG (SYNC_STG)
    ) u_dom_sync (
      .clk   (dom_clk[i]),
      .arstn (arstn),
      .d     (src_rstn_q[i]),
      .q     (rstn_out[i])
    );
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: an edge-timeline model predicts outputs per src_clk edge.
module tb_rst_seq_ctrl;

  localparam int N        = 3;
  localparam int WAIT_CYC = 8;
  localparam int RST_CYC  = 4;
  localparam int STAGGER  = 2;
  localparam int REL_END  = RST_CYC + (N - 1) * STAGGER;
  localparam logic [2:0] INIT_MASK = 3'b011;
`ifdef RST_SEQ_LOCK_MON_EN
  localparam bit LOCK_MON = 1'b1;
`else
  localparam bit LOCK_MON = 1'b0;
`endif

  typedef struct {
    int         n;
    logic       busy;
    logic       done;
    logic [2:0] s;
  } exp_t;

  logic       src_clk = 1'b0;
  logic       dom2_clk = 1'b0;
  logic       arstn;
  logic [2:0] dom_clk;
  logic       pll_locked;
  logic       sw_rst_req;
  logic [2:0] rstn_out;
  logic       rst_busy;
  logic       rst_done;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // Model timeline: edge numbers at which WAIT and RSET are entered (-1 when not scheduled).
  int         n;
  int         wait_edge;
  int         rset_edge;
  logic [2:0] init_s;
  logic       pll_h[$];

  // Monitor-side expectation state.
  logic [2:0] cur_s;
  logic [2:0] h0, h1;
  logic [1:0] d2;
  int         mon_edge;

  assign dom_clk = {dom2_clk, src_clk, src_clk};

  rst_seq_ctrl #(
    .N_DOM     (3),
    .WAIT_CYC  (WAIT_CYC),
    .RST_CYC   (RST_CYC),
    .STAGGER   (STAGGER),
    .SYNC_STG  (2),
    .INIT_MASK (INIT_MASK)
  ) u_dut (
    .src_clk    (src_clk),
    .arstn      (arstn),
    .dom_clk    (dom_clk),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .rstn_out   (rstn_out),
    .rst_busy   (rst_busy),
    .rst_done   (rst_done)
  );

  always #5 src_clk = ~src_clk;

  // Domain 2 runs at a third of src_clk, its rising edges 3 ns after a src_clk rising edge.
  initial begin
    #8;
    forever begin
      dom2_clk = 1'b1;
      #15;
      dom2_clk = 1'b0;
      #15;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, mon_edge, act, exp);
    end
  endtask

  task automatic model_reset();
    n         = 0;
    wait_edge = -1;
    rset_edge = -1;
    init_s    = INIT_MASK;
    pll_h.delete();
    pll_h.push_back(1'b0);
  endtask

  // Predict the outputs right after edge n+1 given the inputs sampled at that edge.
  task automatic model_step(input logic pll, input logic sw);
    exp_t e;
    logic lock_now;
    bit   init_prev, idle_prev;
    int   t, k;
    n++;
    pll_h.push_back(pll);
    lock_now  = (n >= 3) ? pll_h[n-2] : 1'b0;
    init_prev = (wait_edge < 0);
    idle_prev = (rset_edge >= 0) && ((n - 1 - rset_edge) >= REL_END);
    if (LOCK_MON && !init_prev && !lock_now) begin
      wait_edge = -1;
      rset_edge = -1;
      init_s    = 3'b000;
    end else if (init_prev && lock_now) begin
      wait_edge = n;
      rset_edge = n + WAIT_CYC;
    end else if (idle_prev && sw) begin
      rset_edge = n;
    end
    e.n = n;
    if (rset_edge < 0 || n < rset_edge) begin
      e.s    = init_s;
      e.busy = 1'b1;
      e.done = 1'b0;
    end else begin
      t = n - rset_edge;
      if (t < RST_CYC) begin
        e.s = 3'b000;
      end else begin
        k = (t - RST_CYC) / STAGGER + 1;
        if (k > N) k = N;
        e.s = 3'((1 << k) - 1);
      end
      e.busy = (t < REL_END);
      e.done = (t == REL_END);
    end
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, predict, then advance.
  task automatic run(input logic pll, input logic sw, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      pll_locked = pll;
      sw_rst_req = sw;
      model_step(pll, sw);
      @(negedge src_clk);
    end
  endtask

  task automatic pulse_reset(input logic pll_after);
    arstn = 1'b0;
    sb.delete();
    #1;
    chk("arst_rstn_out", 32'(rstn_out), 32'(3'b000));
    chk("arst_busy", 32'(rst_busy), 32'(1'b0));
    chk("arst_done", 32'(rst_done), 32'(1'b0));
    repeat (2) @(negedge src_clk);
    arstn      = 1'b1;
    pll_locked = pll_after;
    model_reset();
  endtask

  always @(posedge src_clk) begin
    exp_t e;
    #1;
    if (!arstn) begin
      mon_edge = 0;
      h0       = 3'b000;
      h1       = 3'b000;
      d2       = 2'b00;
      cur_s    = INIT_MASK;
      chk("rst_rstn_out", 32'(rstn_out), 32'(3'b000));
      chk("rst_busy", 32'(rst_busy), 32'(1'b0));
      chk("rst_done", 32'(rst_done), 32'(1'b0));
    end else if (sb.size() == 0) begin
      mon_edge++;
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      mon_edge++;
      e     = sb.pop_front();
      h1    = h0;
      h0    = cur_s;
      cur_s = e.s;
      chk("busy", 32'(rst_busy), 32'(e.busy));
      chk("done", 32'(rst_done), 32'(e.done));
      chk("rstn_out10", 32'(rstn_out[1:0]), 32'(h1[1:0]));
      // Slow domain must hold its value between its own clock edges.
      chk("rstn_out2_hold", 32'(rstn_out[2]), 32'(d2[1]));
    end
  end

  always @(posedge dom2_clk) begin
    #1;
    if (!arstn) begin
      d2 = 2'b00;
    end else begin
      d2 = {d2[0], cur_s[2]};
      chk("rstn_out2", 32'(rstn_out[2]), 32'(d2[1]));
    end
  end

  initial begin
    arstn      = 1'b0;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    mon_edge   = 0;
    cur_s      = INIT_MASK;
    h0         = 3'b000;
    h1         = 3'b000;
    d2         = 2'b00;
    model_reset();
    repeat (3) @(negedge src_clk);

    // Cold start with lock already high, then a software re-reset from IDLE.
    arstn = 1'b1;
    model_reset();
    run(1'b1, 1'b0, 25);
    run(1'b1, 1'b0, int'($urandom_range(2, 6)));
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 14);

    // Request during WAIT is ignored; asynchronous reset lands mid-RSET.
    pulse_reset(1'b1);
    run(1'b1, 1'b0, 5);
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 6);
    pulse_reset(1'b1);
    run(1'b1, 1'b0, 25);

    // Lock arrives 20 cycles after reset release.
    pulse_reset(1'b0);
    run(1'b0, 1'b0, 20);
    run(1'b1, 1'b0, 35);

    // Lock lost just after domain 0 is released, then regained.
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, int'($urandom_range(3, 6)));
    run(1'b1, 1'b0, 40);

    // Random lock glitches and software requests.
    for (int i = 0; i < 300; i++) begin
      run(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 7) == 0), 1);
    end
    run(1'b1, 1'b0, 30);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
